// File: rtl/pe_operand_streamer.sv
// Operand streamer: reads matrix A (X*N) and matrix B (N*Y) from two 1-cycle-latency RAMs and
// drives them as gap-free, row-major val/data bursts into the systolic-array front end.
module pe_operand_streamer #(
    parameter int X          = 3,
    parameter int N          = 3,
    parameter int Y          = 3,
    parameter int IN_LEN     = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] a_base,
    input  logic [ADDR_WIDTH-1:0] b_base,
    output logic                  busy,
    output logic                  done,
    output logic                  a_rd_en,
    output logic [ADDR_WIDTH-1:0] a_rd_addr,
    input  logic [IN_LEN-1:0]     a_rd_data,
    output logic                  b_rd_en,
    output logic [ADDR_WIDTH-1:0] b_rd_addr,
    input  logic [IN_LEN-1:0]     b_rd_data,
    output logic                  Xin_val,
    output logic [IN_LEN-1:0]     Xin_data,
    output logic                  Yin_val,
    output logic [IN_LEN-1:0]     Yin_data
);

    localparam int A_LEN   = X * N;
    localparam int B_LEN   = N * Y;
    localparam int MAX_LEN = (A_LEN > B_LEN) ? A_LEN : B_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(A_LEN);
    localparam logic [CNT_W-1:0] B_LAST = CNT_W'(B_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                state;
    logic                  flush_cnt;
    logic [CNT_W-1:0]      a_cnt;
    logic [CNT_W-1:0]      b_cnt;
    logic [ADDR_WIDTH-1:0] a_base_q;
    logic [ADDR_WIDTH-1:0] b_base_q;
    logic                  a_en_d1;
    logic                  b_en_d1;

    // Control FSM; the two-cycle FLUSH covers the RAM read latency plus the output register.
    // NOTE: every register here is written with <= so all updates use pre-edge values.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            flush_cnt <= 1'b0;
            a_cnt     <= '0;
            b_cnt     <= '0;
            a_base_q  <= '0;
            b_base_q  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            a_rd_en   <= 1'b0;
            a_rd_addr <= '0;
            b_rd_en   <= 1'b0;
            b_rd_addr <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    a_rd_en   <= 1'b0;
                    a_rd_addr <= '0;
                    b_rd_en   <= 1'b0;
                    b_rd_addr <= '0;
                    if (start) begin
                        a_base_q <= a_base;
                        b_base_q <= b_base;
                        a_cnt    <= '0;
                        b_cnt    <= '0;
                        state    <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    busy <= 1'b1;
                    // Each stream stops on its own; the address wraps mod 2**ADDR_WIDTH.
                    if (a_cnt != A_LAST) begin
                        a_rd_en   <= 1'b1;
                        a_rd_addr <= a_base_q + ADDR_WIDTH'(a_cnt);
                        a_cnt     <= a_cnt + 1'b1;
                    end else begin
                        a_rd_en   <= 1'b0;
                        a_rd_addr <= '0;
                    end
                    if (b_cnt != B_LAST) begin
                        b_rd_en   <= 1'b1;
                        b_rd_addr <= b_base_q + ADDR_WIDTH'(b_cnt);
                        b_cnt     <= b_cnt + 1'b1;
                    end else begin
                        b_rd_en   <= 1'b0;
                        b_rd_addr <= '0;
                    end
                    if ((a_cnt == A_LAST) && (b_cnt == B_LAST)) begin
                        flush_cnt <= 1'b0;
                        state     <= S_FLUSH;
                    end
                end

                S_FLUSH: begin
                    busy      <= 1'b1;
                    a_rd_en   <= 1'b0;
                    a_rd_addr <= '0;
                    b_rd_en   <= 1'b0;
                    b_rd_addr <= '0;
                    if (flush_cnt) begin
                        state <= S_DONE;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end

                S_DONE: begin
                    busy  <= 1'b1;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output pipeline: the enable is delayed to line up with RAM data, then registered with it.
    // NOTE: these are reset too, so an aborted job cannot leak a stale beat after reset.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            a_en_d1  <= 1'b0;
            b_en_d1  <= 1'b0;
            Xin_val  <= 1'b0;
            Xin_data <= '0;
            Yin_val  <= 1'b0;
            Yin_data <= '0;
        end else begin
            a_en_d1  <= a_rd_en;
            b_en_d1  <= b_rd_en;
            Xin_val  <= a_en_d1;
            Xin_data <= a_en_d1 ? a_rd_data : '0;
            Yin_val  <= b_en_d1;
            Yin_data <= b_en_d1 ? b_rd_data : '0;
        end
    end

endmodule

// File: tb/tb_pe_operand_streamer.sv
// Directed bench for pe_operand_streamer: a default 3x3x3 instance and a 2x3x4 instance,
// each fed by a 1-cycle-latency RAM model that returns 0xFF whenever it is not read.
module tb_pe_operand_streamer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       sys_rst;
    logic       start0, start1;
    logic [3:0] a_base, b_base;

    logic       busy0, done0, a_en0, b_en0, xv0, yv0;
    logic [3:0] a_addr0, b_addr0;
    logic [7:0] a_data0, b_data0, xd0, yd0;

    logic       busy1, done1, a_en1, b_en1, xv1, yv1;
    logic [3:0] a_addr1, b_addr1;
    logic [7:0] a_data1, b_data1, xd1, yd1;

    logic [7:0] a_mem [16];
    logic [7:0] b_mem [16];

    int n_checks = 0;
    int n_errors = 0;

    logic       o_busy, o_done, o_a_en, o_b_en, o_xv, o_yv;
    logic [3:0] o_a_addr, o_b_addr;
    logic [7:0] o_xd, o_yd;

    pe_operand_streamer #(.X(3), .N(3), .Y(3), .IN_LEN(8), .ADDR_WIDTH(4)) dut0 (
        .clk(clk), .sys_rst(sys_rst), .start(start0), .a_base(a_base), .b_base(b_base),
        .busy(busy0), .done(done0),
        .a_rd_en(a_en0), .a_rd_addr(a_addr0), .a_rd_data(a_data0),
        .b_rd_en(b_en0), .b_rd_addr(b_addr0), .b_rd_data(b_data0),
        .Xin_val(xv0), .Xin_data(xd0), .Yin_val(yv0), .Yin_data(yd0)
    );

    pe_operand_streamer #(.X(2), .N(3), .Y(4), .IN_LEN(8), .ADDR_WIDTH(4)) dut1 (
        .clk(clk), .sys_rst(sys_rst), .start(start1), .a_base(a_base), .b_base(b_base),
        .busy(busy1), .done(done1),
        .a_rd_en(a_en1), .a_rd_addr(a_addr1), .a_rd_data(a_data1),
        .b_rd_en(b_en1), .b_rd_addr(b_addr1), .b_rd_data(b_data1),
        .Xin_val(xv1), .Xin_data(xd1), .Yin_val(yv1), .Yin_data(yd1)
    );

    // RAM models: idle reads return 0xFF so any unmasked data path shows up on Xin/Yin.
    always @(posedge clk) begin
        a_data0 <= a_en0 ? a_mem[a_addr0] : 8'hFF;
        b_data0 <= b_en0 ? b_mem[b_addr0] : 8'hFF;
        a_data1 <= a_en1 ? a_mem[a_addr1] : 8'hFF;
        b_data1 <= b_en1 ? b_mem[b_addr1] : 8'hFF;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic sample(input bit sel);
        o_busy   = sel ? busy1   : busy0;
        o_done   = sel ? done1   : done0;
        o_a_en   = sel ? a_en1   : a_en0;
        o_a_addr = sel ? a_addr1 : a_addr0;
        o_b_en   = sel ? b_en1   : b_en0;
        o_b_addr = sel ? b_addr1 : b_addr0;
        o_xv     = sel ? xv1     : xv0;
        o_xd     = sel ? xd1     : xd0;
        o_yv     = sel ? yv1     : yv0;
        o_yd     = sel ? yd1     : yd0;
    endtask

    // Expected outputs c cycles after the accepting edge E0; a negative c means "idle".
    task automatic check_outputs(input string tag, input bit sel, input int c,
                                 input logic [3:0] ab, input logic [3:0] bb);
        int         xn = sel ? 6 : 9;
        int         ny = sel ? 12 : 9;
        int         m  = (xn > ny) ? xn : ny;
        bit         ea = (c >= 1) && (c <= xn);
        bit         eb = (c >= 1) && (c <= ny);
        bit         ex = (c >= 3) && (c <= xn + 2);
        bit         ey = (c >= 3) && (c <= ny + 2);
        logic [3:0] ia = 4'(int'(ab) + c - 3);
        logic [3:0] ib = 4'(int'(bb) + c - 3);
        string      p  = $sformatf("%s c=%0d", tag, c);
        sample(sel);
        check({p, " busy"}, o_busy, (c >= 1) && (c <= m + 4));
        check({p, " done"}, o_done, c == m + 4);
        check({p, " a_rd_en"}, o_a_en, ea);
        check({p, " a_rd_addr"}, o_a_addr, ea ? 4'(int'(ab) + c - 1) : 4'd0);
        check({p, " b_rd_en"}, o_b_en, eb);
        check({p, " b_rd_addr"}, o_b_addr, eb ? 4'(int'(bb) + c - 1) : 4'd0);
        check({p, " Xin_val"}, o_xv, ex);
        check({p, " Xin_data"}, o_xd, ex ? 8'h10 + {4'h0, ia} : 8'h00);
        check({p, " Yin_val"}, o_yv, ey);
        check({p, " Yin_data"}, o_yd, ey ? 8'h20 + {4'h0, ib} : 8'h00);
    endtask

    task automatic set_start(input bit sel, input bit v);
        if (sel) start1 = v;
        else     start0 = v;
    endtask

    task automatic idle(input string tag, input bit sel, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            check_outputs(tag, sel, -100, 4'd0, 4'd0);
        end
    endtask

    // One job from the accepting edge through the done cycle; optional extra start pulses,
    // start held for back-to-back, or reset asserted right after the check at cycle rst_at.
    task automatic run_job(input string tag, input bit sel, input logic [3:0] ab,
                           input logic [3:0] bb, input bit hold, input int pulse1,
                           input int pulse2, input int rst_at);
        int m = sel ? 12 : 9;
        a_base = ab;
        b_base = bb;
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        for (int c = 0; c <= m + 4; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            check_outputs(tag, sel, c, ab, bb);
            if (c == rst_at) begin
                sys_rst = 1'b1;
                set_start(sel, 1'b0);
                return;
            end
            set_start(sel, hold || (c == pulse1) || (c == pulse2));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            a_mem[i] = 8'h10 + 8'(i);
            b_mem[i] = 8'h20 + 8'(i);
        end
        sys_rst = 1'b1;
        start0  = 1'b0;
        start1  = 1'b0;
        a_base  = 4'd0;
        b_base  = 4'd0;

        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset0", 1'b0, -100, 4'd0, 4'd0);
        check_outputs("reset1", 1'b1, -100, 4'd0, 4'd0);
        sys_rst = 1'b0;
        idle("post_reset", 1'b0, 2);

        // Basic 3x3x3 job from base 0: beats E3..E11, done at E13.
        run_job("t1", 1'b0, 4'd0, 4'd0, 1'b0, -1, -1, -1);
        idle("t1_idle", 1'b0, 2);

        // A address wraps 14,15,0..6.
        run_job("t2_wrap", 1'b0, 4'd14, 4'd0, 1'b0, -1, -1, -1);
        idle("t2_idle", 1'b0, 2);

        // Unequal bursts: 6 A beats, 12 B beats, done after the B burst.
        run_job("t3_2x3x4", 1'b1, 4'd0, 4'd0, 1'b0, -1, -1, -1);
        idle("t3_idle", 1'b1, 2);

        // Start held: two identical back-to-back jobs, then pulses during busy are ignored.
        run_job("t4_job1", 1'b0, 4'd3, 4'd5, 1'b1, -1, -1, -1);
        run_job("t4_job2", 1'b0, 4'd3, 4'd5, 1'b0, 4, 10, -1);
        idle("t4_no_extra", 1'b0, 5);

        // Reset at the 5th Xin beat drops the job; a fresh job afterwards is complete.
        run_job("t5_abort", 1'b0, 4'd0, 4'd0, 1'b0, -1, -1, 7);
        @(posedge clk); #1;
        check_outputs("t5_in_reset", 1'b0, -100, 4'd0, 4'd0);
        sys_rst = 1'b0;
        idle("t5_no_done", 1'b0, 4);
        run_job("t5_rerun", 1'b0, 4'd0, 4'd0, 1'b0, -1, -1, -1);

        // RAM drives 0xFF between reads; data outputs must stay 0 outside the valid window.
        idle("t6_ff_masked", 1'b0, 3);
        idle("t6_ff_masked1", 1'b1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
